// File: rtl/cal_abs_pipe.sv
// Fully pipelined integer complex magnitude |z| = sqrt(re^2 + im^2), one sample per clock.
// A single global stall freezes every stage whenever the held result is not being taken.
module cal_abs_pipe #(
    parameter int unsigned  DATA_W    = 8,
    parameter int unsigned  SIGNED_IN = 0,
    parameter int unsigned  ROUND     = 0,
    localparam int unsigned OUT_W     = DATA_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_re,
    input  logic [DATA_W-1:0] in_im,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_abs,
    output logic              out_last
);

    localparam int unsigned SQ_W  = 2 * DATA_W;
    localparam int unsigned X_W   = SQ_W + 1;
    localparam int unsigned RAD_W = 2 * OUT_W;
    localparam int unsigned REM_W = OUT_W + 3;
    localparam int unsigned NSQ   = OUT_W - 1;

    logic en;

    logic              s0_vld_q, s0_vld_d, s0_last_q, s0_last_d;
    logic [DATA_W-1:0] mag_re_q, mag_re_d, mag_im_q, mag_im_d;
    logic              s1_vld_q, s1_vld_d, s1_last_q, s1_last_d;
    logic [SQ_W-1:0]   sq_re_q, sq_re_d, sq_im_q, sq_im_d;
    logic              s2_vld_q, s2_vld_d, s2_last_q, s2_last_d;
    logic [X_W-1:0]    x_q, x_d;

    logic              sq_vld_q  [NSQ];
    logic              sq_vld_d  [NSQ];
    logic              sq_last_q [NSQ];
    logic              sq_last_d [NSQ];
    logic [OUT_W-1:0]  sq_root_q [NSQ];
    logic [OUT_W-1:0]  sq_root_d [NSQ];
    logic [REM_W-1:0]  sq_rem_q  [NSQ];
    logic [REM_W-1:0]  sq_rem_d  [NSQ];
    logic [RAD_W-1:0]  sq_rad_q  [NSQ];
    logic [RAD_W-1:0]  sq_rad_d  [NSQ];

    logic              st_vld_i  [OUT_W];
    logic              st_last_i [OUT_W];
    logic [OUT_W-1:0]  st_root_i [OUT_W];
    logic [REM_W-1:0]  st_rem_i  [OUT_W];
    logic [RAD_W-1:0]  st_rad_i  [OUT_W];
    logic [REM_W-1:0]  st_cand   [OUT_W];
    logic [REM_W-1:0]  st_trial  [OUT_W];
    logic [OUT_W-1:0]  st_root_o [OUT_W];
    logic [REM_W-1:0]  st_rem_o  [OUT_W];
    logic [RAD_W-1:0]  st_rad_o  [OUT_W];

    logic              out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic [OUT_W-1:0]  out_abs_q, out_abs_d;

    // Two's-complement magnitude; the most negative value maps cleanly to 2^(DATA_W-1).
    function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v);
        if ((SIGNED_IN != 0) && v[DATA_W-1]) begin
            return ~v + DATA_W'(1);
        end else begin
            return v;
        end
    endfunction

    assign en       = !out_valid_q || out_ready;
    assign in_ready = en;

    // Restoring digit-by-digit square root, one result bit per stage, MSB first.
    always_comb begin
        st_vld_i[0]  = s2_vld_q;
        st_last_i[0] = s2_last_q;
        st_root_i[0] = '0;
        st_rem_i[0]  = '0;
        st_rad_i[0]  = RAD_W'(x_q);
        for (int k = 1; k < OUT_W; k++) begin
            st_vld_i[k]  = sq_vld_q[k-1];
            st_last_i[k] = sq_last_q[k-1];
            st_root_i[k] = sq_root_q[k-1];
            st_rem_i[k]  = sq_rem_q[k-1];
            st_rad_i[k]  = sq_rad_q[k-1];
        end
        for (int k = 0; k < OUT_W; k++) begin
            st_cand[k]  = REM_W'({st_rem_i[k], st_rad_i[k][RAD_W-1 -: 2]});
            st_trial[k] = REM_W'({st_root_i[k], 2'b01});
            st_rad_o[k] = RAD_W'({st_rad_i[k], 2'b00});
            if (st_cand[k] >= st_trial[k]) begin
                st_rem_o[k]  = st_cand[k] - st_trial[k];
                st_root_o[k] = OUT_W'({st_root_i[k], 1'b1});
            end else begin
                st_rem_o[k]  = st_cand[k];
                st_root_o[k] = OUT_W'({st_root_i[k], 1'b0});
            end
        end
    end

    always_comb begin
        s0_vld_d  = in_valid;
        s0_last_d = in_last;
        mag_re_d  = mag(in_re);
        mag_im_d  = mag(in_im);

        s1_vld_d  = s0_vld_q;
        s1_last_d = s0_last_q;
        sq_re_d   = SQ_W'(mag_re_q) * SQ_W'(mag_re_q);
        sq_im_d   = SQ_W'(mag_im_q) * SQ_W'(mag_im_q);

        s2_vld_d  = s1_vld_q;
        s2_last_d = s1_last_q;
        x_d       = X_W'(sq_re_q) + X_W'(sq_im_q);

        for (int k = 0; k < NSQ; k++) begin
            sq_vld_d[k]  = st_vld_i[k];
            sq_last_d[k] = st_last_i[k];
            sq_root_d[k] = st_root_o[k];
            sq_rem_d[k]  = st_rem_o[k];
            sq_rad_d[k]  = st_rad_o[k];
        end

        // Remainder X - r^2 above r means sqrt(X) >= r + 0.5.
        out_valid_d = st_vld_i[OUT_W-1];
        out_last_d  = st_last_i[OUT_W-1];
        out_abs_d   = st_root_o[OUT_W-1];
        if ((ROUND != 0) && (st_rem_o[OUT_W-1] > REM_W'(st_root_o[OUT_W-1]))) begin
            out_abs_d = st_root_o[OUT_W-1] + OUT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_vld_q    <= 1'b0;
            s0_last_q   <= 1'b0;
            mag_re_q    <= '0;
            mag_im_q    <= '0;
            s1_vld_q    <= 1'b0;
            s1_last_q   <= 1'b0;
            sq_re_q     <= '0;
            sq_im_q     <= '0;
            s2_vld_q    <= 1'b0;
            s2_last_q   <= 1'b0;
            x_q         <= '0;
            sq_vld_q    <= '{default: 1'b0};
            sq_last_q   <= '{default: 1'b0};
            sq_root_q   <= '{default: '0};
            sq_rem_q    <= '{default: '0};
            sq_rad_q    <= '{default: '0};
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_abs_q   <= '0;
        end else if (en) begin
            s0_vld_q    <= s0_vld_d;
            s0_last_q   <= s0_last_d;
            mag_re_q    <= mag_re_d;
            mag_im_q    <= mag_im_d;
            s1_vld_q    <= s1_vld_d;
            s1_last_q   <= s1_last_d;
            sq_re_q     <= sq_re_d;
            sq_im_q     <= sq_im_d;
            s2_vld_q    <= s2_vld_d;
            s2_last_q   <= s2_last_d;
            x_q         <= x_d;
            sq_vld_q    <= sq_vld_d;
            sq_last_q   <= sq_last_d;
            sq_root_q   <= sq_root_d;
            sq_rem_q    <= sq_rem_d;
            sq_rad_q    <= sq_rad_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_abs_q   <= out_abs_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_abs   = out_abs_q;

endmodule

// File: tb/tb_cal_abs_pipe.sv
// Scoreboard bench for cal_abs_pipe: floor, round and signed instances share one stimulus stream.
module tb_cal_abs_pipe;

    localparam int unsigned DW  = 8;
    localparam int unsigned OW  = DW + 1;
    localparam int          LAT = 12;

    logic          clk = 1'b0;
    logic          rst_n, in_valid, in_last, out_ready;
    logic [DW-1:0] in_re, in_im;
    logic          in_ready_fl, in_ready_rd, in_ready_sg;
    logic          out_valid_fl, out_valid_rd, out_valid_sg;
    logic          out_last_fl, out_last_rd, out_last_sg;
    logic [OW-1:0] out_abs_fl, out_abs_rd, out_abs_sg;

    typedef struct {
        int fl;
        int rd;
        int sg;
        bit last;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   cyc    = 0;
    bit   lat_chk = 1'b1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cal_abs_pipe #(.DATA_W(DW), .SIGNED_IN(0), .ROUND(0)) u_fl (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_fl),
        .in_re(in_re), .in_im(in_im), .in_last(in_last), .out_valid(out_valid_fl),
        .out_ready(out_ready), .out_abs(out_abs_fl), .out_last(out_last_fl));

    cal_abs_pipe #(.DATA_W(DW), .SIGNED_IN(0), .ROUND(1)) u_rd (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_rd),
        .in_re(in_re), .in_im(in_im), .in_last(in_last), .out_valid(out_valid_rd),
        .out_ready(out_ready), .out_abs(out_abs_rd), .out_last(out_last_rd));

    cal_abs_pipe #(.DATA_W(DW), .SIGNED_IN(1), .ROUND(0)) u_sg (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_sg),
        .in_re(in_re), .in_im(in_im), .in_last(in_last), .out_valid(out_valid_sg),
        .out_ready(out_ready), .out_abs(out_abs_sg), .out_last(out_last_sg));

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    // Brute-force integer square root of re^2 + im^2.
    function automatic int model(input logic [DW-1:0] re, input logic [DW-1:0] im,
                                 input bit sgn, input bit rnd);
        int a, b, x, r;
        a = (sgn && re[DW-1]) ? 256 - int'(re) : int'(re);
        b = (sgn && im[DW-1]) ? 256 - int'(im) : int'(im);
        x = a * a + b * b;
        r = 0;
        while ((r + 1) * (r + 1) <= x) r++;
        if (rnd && (x - r * r > r)) r++;
        return r;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (out_valid_fl && out_ready) begin
                if (sb.size() == 0) begin
                    check("spurious_out", int'(out_valid_fl), 0);
                end else begin
                    e = sb.pop_front();
                    check("abs_floor",   int'(out_abs_fl), e.fl);
                    check("abs_round",   int'(out_abs_rd), e.rd);
                    check("abs_signed",  int'(out_abs_sg), e.sg);
                    check("valid_round", int'(out_valid_rd), 1);
                    check("valid_signed", int'(out_valid_sg), 1);
                    check("last_floor",  int'(out_last_fl), int'(e.last));
                    check("last_round",  int'(out_last_rd), int'(e.last));
                    check("last_signed", int'(out_last_sg), int'(e.last));
                    if (lat_chk) check("latency", cyc - e.cyc, LAT);
                end
            end else if (!out_valid_fl) begin
                if (out_valid_rd) check("valid_align_round", int'(out_valid_rd), 0);
                if (out_valid_sg) check("valid_align_signed", int'(out_valid_sg), 0);
            end
            if (in_valid && in_ready_fl) begin
                e.fl   = model(in_re, in_im, 1'b0, 1'b0);
                e.rd   = model(in_re, in_im, 1'b0, 1'b1);
                e.sg   = model(in_re, in_im, 1'b1, 1'b0);
                e.last = in_last;
                e.cyc  = cyc;
                sb.push_back(e);
            end
        end
    end

    task automatic send(input logic [DW-1:0] re, input logic [DW-1:0] im, input bit last);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_re    = re;
        in_im    = im;
        in_last  = last;
        @(negedge clk);
        while (!in_ready_fl && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready_fl) check("send_timeout", int'(in_ready_fl), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic stall(input logic [DW-1:0] re, input logic [DW-1:0] im);
        in_valid  = 1'b1;
        in_re     = re;
        in_im     = im;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("stall_in_ready_floor",  int'(in_ready_fl), 0);
            check("stall_in_ready_round",  int'(in_ready_rd), 0);
            check("stall_in_ready_signed", int'(in_ready_sg), 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        in_valid = 1'b0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        check("drain_empty", sb.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] r, m;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_re     = '0;
        in_im     = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        #12;
        check("rst_valid",  int'(out_valid_fl), 0);
        check("rst_abs",    int'(out_abs_fl), 0);
        check("rst_last",   int'(out_last_fl), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", int'(in_ready_fl), 1);

        // Directed values for each configuration, back to back.
        send(8'd3, 8'd4, 1'b0);
        send(8'd0, 8'd0, 1'b0);
        send(8'd255, 8'd255, 1'b0);
        send(8'd1, 8'd1, 1'b0);
        send(8'd2, 8'd3, 1'b0);
        send(8'h80, 8'h80, 1'b0);
        send(8'hFD, 8'h04, 1'b0);
        send(8'h7F, 8'h80, 1'b0);
        drain();

        // Random stream with two 5-cycle output stalls.
        lat_chk = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            r = DW'($urandom);
            m = DW'($urandom);
            if (i == 20 || i == 500) stall(r, m);
            send(r, m, 1'b0);
        end
        drain();
        lat_chk = 1'b1;

        // Frame with alternating bubbles and last on the 16th sample.
        for (int i = 0; i < 16; i++) begin
            send(DW'($urandom), DW'($urandom), i == 15);
            if (i != 15) idle(1);
        end
        drain();

        // Reset while results are in flight.
        for (int i = 0; i < 18; i++) send(DW'($urandom), DW'($urandom), i == 17);
        #2;
        check("pre_reset_valid", int'(out_valid_fl), 1);
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("async_rst_valid_floor",  int'(out_valid_fl), 0);
        check("async_rst_valid_round",  int'(out_valid_rd), 0);
        check("async_rst_valid_signed", int'(out_valid_sg), 0);
        check("async_rst_abs_floor",    int'(out_abs_fl), 0);
        check("async_rst_abs_round",    int'(out_abs_rd), 0);
        check("async_rst_last_floor",   int'(out_last_fl), 0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_in_ready_floor",  int'(in_ready_fl), 1);
        check("post_rst_in_ready_round",  int'(in_ready_rd), 1);
        check("post_rst_in_ready_signed", int'(in_ready_sg), 1);
        send(8'd3, 8'd4, 1'b0);
        drain();
        idle(20);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
